// File: rtl/loop_sequencer.sv
// Hardware for-loop engine: issues init, init+step, ... while index < limit over a
// valid/ready handshake, then reports the exit index and whether it overflowed.
module loop_sequencer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] cfg_init,
    input  logic [W-1:0] cfg_limit,
    input  logic [W-1:0] cfg_step,
    input  logic         abort,
    output logic         idx_valid,
    input  logic         idx_ready,
    output logic [W-1:0] idx,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] final_idx,
    output logic         wrapped,
    output logic         err
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t       state;
    logic [W-1:0] step_q;
    logic [W-1:0] limit_q;
    logic [W:0]   nxt;

    // One extra bit so an overflowing increment is seen as a carry, not a small value.
    assign nxt = {1'b0, idx} + {1'b0, step_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            step_q    <= '0;
            limit_q   <= '0;
            idx       <= '0;
            idx_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            final_idx <= '0;
            wrapped   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        if (cfg_step == '0) begin
                            err <= 1'b1;
                        end else if (cfg_init >= cfg_limit) begin
                            state     <= StDone;
                            busy      <= 1'b1;
                            done      <= 1'b1;
                            final_idx <= cfg_init;
                            wrapped   <= 1'b0;
                        end else begin
                            state     <= StRun;
                            busy      <= 1'b1;
                            idx_valid <= 1'b1;
                            idx       <= cfg_init;
                            step_q    <= cfg_step;
                            limit_q   <= cfg_limit;
                        end
                    end
                end
                StRun: begin
                    // Abort wins even over a handshake that would have ended the loop.
                    if (abort) begin
                        state     <= StIdle;
                        busy      <= 1'b0;
                        idx_valid <= 1'b0;
                    end else if (idx_ready) begin
                        if (nxt[W] || (nxt[W-1:0] >= limit_q)) begin
                            state     <= StDone;
                            idx_valid <= 1'b0;
                            done      <= 1'b1;
                            final_idx <= nxt[W-1:0];
                            wrapped   <= nxt[W];
                        end else begin
                            idx <= nxt[W-1:0];
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= StIdle;
                    busy      <= 1'b0;
                    idx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/loop_sequencer.md
# loop_sequencer

Hardware for-loop engine that sequences a counting datapath. A single start pulse latches init, limit and step values. The block then issues the loop index values init, init+step, … one per valid/ready handshake while index < limit. On exit it reports the terminating index value, in the way a counter holds its exit value after a software for-loop. It sits between a control/configuration source and any consumer that processes one index per transfer (address generator, stimulus driver, DMA beat counter).

## Interface

- W, 4, width of the index, init, limit and step values.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a loop; sampled only in IDLE.
- cfg_init  in  W  first index value; sampled with start.
- cfg_limit  in  W  exclusive upper bound; sampled with start.
- cfg_step  in  W  increment; sampled with start; 0 is illegal.
- abort  in  1  terminates a running loop without done.
- idx_valid  out  1  index available.
- idx_ready  in  1  consumer accepts index.
- idx  out  W  current index value.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse on normal loop exit.
- final_idx  out  W  exit index value; holds until the next accepted start.
- wrapped  out  1  the exit was caused by W-bit overflow; holds with final_idx.
- err  out  1  one-cycle pulse when start is rejected (step == 0).

## Operation

- FSM states: IDLE, RUN, DONE.
- Reset (async) values: state = IDLE; idx_valid, busy, done, err, wrapped = 0; idx, final_idx = 0.
- IDLE + start:
  - cfg_step == 0: err = 1 for the next cycle, stay IDLE, and leave final_idx/wrapped unchanged.
  - cfg_init >= cfg_limit: zero-iteration loop. Go to DONE with final_idx = cfg_init and wrapped = 0. No idx_valid is asserted.
  - Otherwise: latch the config, set cur = cfg_init, and go to RUN.
- RUN:
  - idx_valid = 1 and idx = cur.
  - idx stays stable while idx_valid && !idx_ready.
- RUN, on a handshake (idx_valid && idx_ready), form next = {1'b0,cur} + {1'b0,step}, computed W+1 bits wide.
  - next[W] == 1 (carry): go to DONE with final_idx = next[W-1:0] and wrapped = 1.
  - next[W-1:0] >= limit: go to DONE with final_idx = next[W-1:0] and wrapped = 0.
  - Otherwise: cur = next[W-1:0] and stay in RUN.
- DONE: done = 1 for exactly one cycle, then IDLE.
- abort in RUN: go to IDLE next cycle with no done pulse. final_idx/wrapped are left unchanged.
  - If abort and a handshake occur in the same cycle, that transfer counts as completed on the consumer side, and abort still wins over DONE.
- abort in IDLE or DONE: ignored.
- start in RUN or DONE: ignored, with no err.
- All comparisons are unsigned.

## Timing

- start sampled at edge N: in cycle N+1 either idx_valid = 1 (RUN), done = 1 (zero-iteration), or err = 1.
- With idx_ready held high: one index per cycle, no bubbles.
- Last handshake at edge M: done = 1 and final_idx/wrapped valid in cycle M+1. idx_valid is 0 in cycle M+1.
- IDLE in cycle M+2; a start sampled at edge M+2 is accepted.
- rst asserted mid-RUN: outputs return to their reset values immediately (asynchronously). No done pulse.

## Test plan

- init=2, limit=14, step=2, idx_ready=1 -> idx 2,4,6,8,10,12 on six consecutive valid cycles. done in the 7th cycle with final_idx=14 and wrapped=0.
- Same config, idx_ready toggling 1/0 every cycle -> idx holds during stalls. The sequence and final_idx=14 are unchanged, and done arrives after the 6th handshake.
- init=10, limit=15, step=4 -> idx 10,14. The next sum is 18, which carries -> done with final_idx=2 and wrapped=1.
- init=14, limit=14, step=2 -> no idx_valid; done one cycle after start with final_idx=14. Then step=0 -> err pulse, no busy, final_idx still 14.
- init=0, limit=8, step=1, with abort after idx=3 is accepted -> IDLE next cycle, no done, final_idx unchanged. start one cycle later is accepted.
- rst pulse while idx=5 is pending -> idx_valid/busy drop immediately, all outputs 0. A new start after rst release runs from cfg_init.
